// File: rtl/ptp_as_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ptp_as_pkg
//  Description : Shared PTP/AS types and constants. Holds the Sync pairing
//                state encoding, the default timestamp width and the fill bit
//                used to build saturated (all-ones) magnitudes.
//  Revision    : 1.0  initial release
// ============================================================================
package ptp_as_pkg;

  // Flat nanosecond timestamp width used unless a block overrides it
  localparam int c_ts_w_default = 80;

  // A saturated magnitude is built by replicating this bit across the width
  localparam logic c_sat_fill = 1'b1;

  // Pairing state of one port: which half of a Sync pair is currently held
  typedef enum logic [1:0] {
    PAIR_IDLE        = 2'd0,
    PAIR_WAIT_T4     = 2'd1,
    PAIR_WAIT_FIELDS = 2'd2,
    PAIR_READY       = 2'd3
  } pair_state_e;

endpackage : ptp_as_pkg
`default_nettype wire

// File: rtl/ptp_sync_pair_chan.sv
`default_nettype none
// ============================================================================
//  Module      : ptp_sync_pair_chan
//  Description : One port's Sync pairing channel. Holds the timing fields and
//                the local receive timestamp t4 until both halves are present,
//                discards a half that waits too long, and flags every
//                discarded or ignored half with a one-cycle drop pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module ptp_sync_pair_chan
  import ptp_as_pkg::*;
#(
  parameter int TS_W        = c_ts_w_default,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fields_valid,
  input  logic [TS_W-1:0] i_origin,
  input  logic [TS_W-1:0] i_pdelay,
  input  logic [TS_W-1:0] i_corr,
  input  logic            i_t4_valid,
  input  logic [TS_W-1:0] i_t4,
  input  logic            i_grant,
  output logic            o_ready,
  output logic            o_drop,
  output logic [TS_W-1:0] o_origin,
  output logic [TS_W-1:0] o_pdelay,
  output logic [TS_W-1:0] o_corr,
  output logic [TS_W-1:0] o_t4
);

  localparam int              CNT_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TIMEOUT_CYC - 1);

  pair_state_e      r_state;
  pair_state_e      w_state_nxt;
  logic [CNT_W-1:0] r_timer;
  logic             w_timeout;
  logic             w_ld_fields;
  logic             w_ld_t4;
  logic             w_timer_clr;
  logic             w_drop;
  logic [TS_W-1:0]  r_origin;
  logic [TS_W-1:0]  r_pdelay;
  logic [TS_W-1:0]  r_corr;
  logic [TS_W-1:0]  r_t4;

  // A half-pair has waited its full budget once the counter hits the last count
  assign w_timeout = (r_timer == c_cnt_last);

  // Where a port with nothing held goes for a given pair of strobes
  function automatic pair_state_e accept_from_idle(input logic f, input logic t);
    if (f && t)  return PAIR_READY;
    else if (f)  return PAIR_WAIT_T4;
    else if (t)  return PAIR_WAIT_FIELDS;
    else         return PAIR_IDLE;
  endfunction

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= PAIR_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state: pair up halves, expire stale ones, release on grant
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PAIR_IDLE: w_state_nxt = accept_from_idle(i_fields_valid, i_t4_valid);
      PAIR_WAIT_T4: begin
        if (i_t4_valid)          w_state_nxt = PAIR_READY;
        else if (i_fields_valid) w_state_nxt = PAIR_WAIT_T4;
        else if (w_timeout)      w_state_nxt = PAIR_IDLE;
      end
      PAIR_WAIT_FIELDS: begin
        if (i_fields_valid)      w_state_nxt = PAIR_READY;
        else if (i_t4_valid)     w_state_nxt = PAIR_WAIT_FIELDS;
        else if (w_timeout)      w_state_nxt = PAIR_IDLE;
      end
      PAIR_READY: begin
        if (i_grant) w_state_nxt = accept_from_idle(i_fields_valid, i_t4_valid);
      end
      default: w_state_nxt = PAIR_IDLE;
    endcase
  end

  // Outputs: capture enables, timer restart and drop pulse per state
  always_comb begin
    w_ld_fields = 1'b0;
    w_ld_t4     = 1'b0;
    w_timer_clr = 1'b1;
    w_drop      = 1'b0;
    case (r_state)
      PAIR_IDLE: begin
        w_ld_fields = i_fields_valid;
        w_ld_t4     = i_t4_valid;
      end
      PAIR_WAIT_T4: begin
        w_ld_fields = i_fields_valid;
        w_ld_t4     = i_t4_valid;
        // repeated fields replace the held ones and restart the wait
        w_timer_clr = i_fields_valid && !i_t4_valid;
        w_drop      = (i_fields_valid && !i_t4_valid) ||
                      (!i_fields_valid && !i_t4_valid && w_timeout);
      end
      PAIR_WAIT_FIELDS: begin
        w_ld_fields = i_fields_valid;
        w_ld_t4     = i_t4_valid;
        w_timer_clr = i_t4_valid && !i_fields_valid;
        w_drop      = (i_t4_valid && !i_fields_valid) ||
                      (!i_fields_valid && !i_t4_valid && w_timeout);
      end
      PAIR_READY: begin
        if (i_grant) begin
          w_ld_fields = i_fields_valid;
          w_ld_t4     = i_t4_valid;
        end else begin
          w_drop      = i_fields_valid || i_t4_valid;
        end
      end
      default: ;
    endcase
  end

  // Held halves of the pair
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_origin <= '0;
      r_pdelay <= '0;
      r_corr   <= '0;
      r_t4     <= '0;
    end else begin
      if (w_ld_fields) begin
        r_origin <= i_origin;
        r_pdelay <= i_pdelay;
        r_corr   <= i_corr;
      end
      if (w_ld_t4) r_t4 <= i_t4;
    end
  end

  // Wait timer: held at zero outside the WAIT states so it starts fresh
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)            r_timer <= '0;
    else if (w_timer_clr) r_timer <= '0;
    else                  r_timer <= r_timer + 1'b1;
  end

  assign o_ready  = (r_state == PAIR_READY);
  assign o_drop   = w_drop;
  assign o_origin = r_origin;
  assign o_pdelay = r_pdelay;
  assign o_corr   = r_corr;
  assign o_t4     = r_t4;

endmodule : ptp_sync_pair_chan
`default_nettype wire

// File: rtl/ptp_sync_offset_calc.sv
`default_nettype none
// ============================================================================
//  Module      : ptp_sync_offset_calc
//  Description : Multi-port Sync offset calculator. Per-port pairing channels
//                feed a round-robin arbiter that issues one completed pair per
//                cycle into a 4-stage adder/subtractor pipeline producing the
//                signed master-minus-slave offset, tagged with its port.
//  Revision    : 1.0  initial release
// ============================================================================
module ptp_sync_offset_calc
  import ptp_as_pkg::*;
#(
  parameter int TS_W        = c_ts_w_default,
  parameter int NUM_PORTS   = 4,
  parameter int TIMEOUT_CYC = 1000000,
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [NUM_PORTS*TS_W-1:0] i_sync_origintimestamp,
  input  logic [NUM_PORTS*TS_W-1:0] i_slaveport_pdelay,
  input  logic [NUM_PORTS*TS_W-1:0] i_correctionfield,
  input  logic [NUM_PORTS-1:0]      i_clockoffsettime_valid,
  input  logic [NUM_PORTS*TS_W-1:0] i_sync_in_t4,
  input  logic [NUM_PORTS-1:0]      i_sync_in_t4_valid,
  output logic [TS_W-1:0]           o_slave_clockoffset,
  output logic                      o_slave_clockoffset_sign,
  output logic [PORT_W-1:0]         o_slave_clockoffset_port,
  output logic                      o_slave_clockoffset_valid,
  output logic                      o_offset_sat,
  output logic [NUM_PORTS-1:0]      o_pair_drop
);

  localparam logic [PORT_W-1:0] c_last_port = PORT_W'(NUM_PORTS - 1);

  logic [NUM_PORTS-1:0] w_ready;
  logic [NUM_PORTS-1:0] w_gnt;
  logic [TS_W-1:0]      w_origin [NUM_PORTS];
  logic [TS_W-1:0]      w_pdelay [NUM_PORTS];
  logic [TS_W-1:0]      w_corr   [NUM_PORTS];
  logic [TS_W-1:0]      w_t4     [NUM_PORTS];

  logic                 w_gnt_any;
  logic [PORT_W-1:0]    w_gnt_idx;
  logic [TS_W-1:0]      w_sel_origin, w_sel_pdelay, w_sel_corr, w_sel_t4;
  logic [PORT_W-1:0]    r_ptr;

  logic [TS_W:0]        r_s1_sum;
  logic [TS_W-1:0]      r_s1_corr, r_s1_t4;
  logic [PORT_W-1:0]    r_s1_port;
  logic                 r_s1_v;
  logic [TS_W+1:0]      r_s2_sum;
  logic [TS_W-1:0]      r_s2_t4;
  logic [PORT_W-1:0]    r_s2_port;
  logic                 r_s2_v;
  logic [TS_W+2:0]      r_s3_diff;
  logic [PORT_W-1:0]    r_s3_port;
  logic                 r_s3_v;

  logic                 w_s3_neg;
  logic [TS_W+2:0]      w_s3_mag;
  logic                 w_s3_sat;

  logic [TS_W-1:0]      r_out_mag;
  logic                 r_out_sign;
  logic [PORT_W-1:0]    r_out_port;
  logic                 r_out_v;
  logic                 r_out_sat;

  generate
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
      ptp_sync_pair_chan #(
        .TS_W        (TS_W),
        .TIMEOUT_CYC (TIMEOUT_CYC)
      ) u_chan (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_fields_valid (i_clockoffsettime_valid[p]),
        .i_origin       (i_sync_origintimestamp[p*TS_W +: TS_W]),
        .i_pdelay       (i_slaveport_pdelay[p*TS_W +: TS_W]),
        .i_corr         (i_correctionfield[p*TS_W +: TS_W]),
        .i_t4_valid     (i_sync_in_t4_valid[p]),
        .i_t4           (i_sync_in_t4[p*TS_W +: TS_W]),
        .i_grant        (w_gnt[p]),
        .o_ready        (w_ready[p]),
        .o_drop         (o_pair_drop[p]),
        .o_origin       (w_origin[p]),
        .o_pdelay       (w_pdelay[p]),
        .o_corr         (w_corr[p]),
        .o_t4           (w_t4[p])
      );
    end
  endgenerate

  // Round-robin pick: first READY port at or after the pointer, plus its operands
  always_comb begin
    w_gnt_any    = 1'b0;
    w_gnt_idx    = '0;
    w_gnt        = '0;
    w_sel_origin = '0;
    w_sel_pdelay = '0;
    w_sel_corr   = '0;
    w_sel_t4     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (!w_gnt_any && w_ready[p] && (p == ((int'(r_ptr) + i) % NUM_PORTS))) begin
          w_gnt_any    = 1'b1;
          w_gnt_idx    = PORT_W'(p);
          w_gnt[p]     = 1'b1;
          w_sel_origin = w_origin[p];
          w_sel_pdelay = w_pdelay[p];
          w_sel_corr   = w_corr[p];
          w_sel_t4     = w_t4[p];
        end
      end
    end
  end

  // Arbiter pointer moves just past the port that was served
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_ptr <= '0;
    else if (w_gnt_any) r_ptr <= (w_gnt_idx == c_last_port) ? '0 : w_gnt_idx + 1'b1;
  end

  // Stage 1: origin + path delay
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1_sum  <= '0;
      r_s1_corr <= '0;
      r_s1_t4   <= '0;
      r_s1_port <= '0;
      r_s1_v    <= 1'b0;
    end else begin
      r_s1_sum  <= {1'b0, w_sel_origin} + {1'b0, w_sel_pdelay};
      r_s1_corr <= w_sel_corr;
      r_s1_t4   <= w_sel_t4;
      r_s1_port <= w_gnt_idx;
      r_s1_v    <= w_gnt_any;
    end
  end

  // Stage 2: add the accumulated correction to get the master time at arrival
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s2_sum  <= '0;
      r_s2_t4   <= '0;
      r_s2_port <= '0;
      r_s2_v    <= 1'b0;
    end else begin
      r_s2_sum  <= {1'b0, r_s1_sum} + {2'b00, r_s1_corr};
      r_s2_t4   <= r_s1_t4;
      r_s2_port <= r_s1_port;
      r_s2_v    <= r_s1_v;
    end
  end

  // Stage 3: master minus slave, one extra bit so the result is two's complement
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s3_diff <= '0;
      r_s3_port <= '0;
      r_s3_v    <= 1'b0;
    end else begin
      r_s3_diff <= {1'b0, r_s2_sum} - {3'b000, r_s2_t4};
      r_s3_port <= r_s2_port;
      r_s3_v    <= r_s2_v;
    end
  end

  // Sign/magnitude split; anything above TS_W bits clamps to all-ones
  assign w_s3_neg = r_s3_diff[TS_W+2];
  assign w_s3_mag = w_s3_neg ? (~r_s3_diff + 1'b1) : r_s3_diff;
  assign w_s3_sat = |w_s3_mag[TS_W+2:TS_W];

  // Stage 4: output register; data holds between results, strobes pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_mag  <= '0;
      r_out_sign <= 1'b0;
      r_out_port <= '0;
      r_out_v    <= 1'b0;
      r_out_sat  <= 1'b0;
    end else begin
      r_out_v   <= r_s3_v;
      r_out_sat <= r_s3_v && w_s3_sat;
      if (r_s3_v) begin
        r_out_mag  <= w_s3_sat ? {TS_W{c_sat_fill}} : w_s3_mag[TS_W-1:0];
        r_out_sign <= w_s3_neg;
        r_out_port <= r_s3_port;
      end
    end
  end

  assign o_slave_clockoffset       = r_out_mag;
  assign o_slave_clockoffset_sign  = r_out_sign;
  assign o_slave_clockoffset_port  = r_out_port;
  assign o_slave_clockoffset_valid = r_out_v;
  assign o_offset_sat              = r_out_sat;

endmodule : ptp_sync_offset_calc
`default_nettype wire

// File: tb/tb_ptp_sync_offset_calc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ptp_sync_offset_calc
//  Description : Directed and randomized bench for ptp_sync_offset_calc. A
//                4-port, 40-bit instance with a short timeout carries pairing,
//                ordering, timeout and reset scenarios; a 3-port, 8-bit
//                instance carries the saturation boundaries.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ptp_sync_offset_calc;

  localparam int AW = 40;
  localparam int AP = 4;
  localparam int BW = 8;
  localparam int BP = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AP*AW-1:0] a_orig = '0, a_pd = '0, a_corr = '0, a_t4 = '0;
  logic [AP-1:0]    a_fv = '0, a_tv = '0;
  logic [AW-1:0]    a_off;
  logic             a_sign, a_valid, a_sat;
  logic [1:0]       a_port;
  logic [AP-1:0]    a_drop;

  logic [BP*BW-1:0] b_orig = '0, b_pd = '0, b_corr = '0, b_t4 = '0;
  logic [BP-1:0]    b_fv = '0, b_tv = '0;
  logic [BW-1:0]    b_off;
  logic             b_sign, b_valid, b_sat;
  logic [1:0]       b_port;
  logic [BP-1:0]    b_drop;

  ptp_sync_offset_calc #(.TS_W(AW), .NUM_PORTS(AP), .TIMEOUT_CYC(16)) u_dut_a (
    .i_clk(clk), .i_rst(rst),
    .i_sync_origintimestamp(a_orig), .i_slaveport_pdelay(a_pd),
    .i_correctionfield(a_corr), .i_clockoffsettime_valid(a_fv),
    .i_sync_in_t4(a_t4), .i_sync_in_t4_valid(a_tv),
    .o_slave_clockoffset(a_off), .o_slave_clockoffset_sign(a_sign),
    .o_slave_clockoffset_port(a_port), .o_slave_clockoffset_valid(a_valid),
    .o_offset_sat(a_sat), .o_pair_drop(a_drop)
  );

  ptp_sync_offset_calc #(.TS_W(BW), .NUM_PORTS(BP), .TIMEOUT_CYC(16)) u_dut_b (
    .i_clk(clk), .i_rst(rst),
    .i_sync_origintimestamp(b_orig), .i_slaveport_pdelay(b_pd),
    .i_correctionfield(b_corr), .i_clockoffsettime_valid(b_fv),
    .i_sync_in_t4(b_t4), .i_sync_in_t4_valid(b_tv),
    .o_slave_clockoffset(b_off), .o_slave_clockoffset_sign(b_sign),
    .o_slave_clockoffset_port(b_port), .o_slave_clockoffset_valid(b_valid),
    .o_offset_sat(b_sat), .o_pair_drop(b_drop)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int m_ptr  = 0;   // model of the round-robin pointer: port after the last one served

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: offset = (origin + pdelay + corr) - t4 with plain integer math
  task automatic exp_calc(input longint o, d, c, t, input int w,
                          output logic [63:0] mag, output logic sgn, output logic sat);
    longint diff, a, lim;
    diff = o + d + c - t;
    sgn  = (diff < 0);
    a    = sgn ? -diff : diff;
    lim  = longint'(1) << w;
    sat  = (a >= lim);
    mag  = sat ? 64'(lim - 1) : 64'(a);
  endtask

  function automatic longint rnd40();
    return longint'($urandom) | (longint'($urandom_range(255, 0)) << 32);
  endfunction

  // Advance to the next cycle; strobes are one-cycle unless set again
  task automatic nxt();
    @(negedge clk);
    a_fv = '0; a_tv = '0; b_fv = '0; b_tv = '0;
    cyc++;
  endtask

  task automatic set_fields(input int p, input longint o, d, c);
    a_orig[p*AW +: AW] = o[AW-1:0];
    a_pd[p*AW +: AW]   = d[AW-1:0];
    a_corr[p*AW +: AW] = c[AW-1:0];
    a_fv[p] = 1'b1;
  endtask

  task automatic set_t4(input int p, input longint t);
    a_t4[p*AW +: AW] = t[AW-1:0];
    a_tv[p] = 1'b1;
  endtask

  task automatic wait_valid_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      nxt(); #1;
      if (a_valid === 1'b1) ok = 1'b1;
    end
  endtask

  // One pair on port p: order 0 fields first, 1 t4 first, 2 same cycle
  task automatic pair(input int p, input int order, input int gap,
                      input longint o, d, c, t);
    logic [63:0] em; logic es, esat; bit ok;
    exp_calc(o, d, c, t, AW, em, es, esat);
    nxt();
    if (order == 2) begin
      set_fields(p, o, d, c); set_t4(p, t);
    end else begin
      if (order == 0) set_fields(p, o, d, c); else set_t4(p, t);
      repeat (gap + 1) nxt();
      if (order == 0) set_t4(p, t); else set_fields(p, o, d, c);
    end
    wait_valid_a(12, ok);
    chk("pair_valid", 64'(ok), 1);
    chk("pair_port",  64'(a_port), 64'(p));
    chk("pair_mag",   64'(a_off), em);
    chk("pair_sign",  64'(a_sign), 64'(es));
    chk("pair_sat",   64'(a_sat), 64'(esat));
    m_ptr = (p + 1) % AP;
  endtask

  // All ports complete in one cycle; results must come out back-to-back from the pointer
  task automatic burst(input string tag);
    longint o[AP], d[AP], c[AP], t[AP];
    logic [63:0] em; logic es, esat; bit ok;
    int p;
    nxt();
    for (int q = 0; q < AP; q++) begin
      o[q] = rnd40(); d[q] = $urandom_range(9000, 0); c[q] = $urandom_range(9000, 0);
      t[q] = o[q] + $urandom_range(20000, 0) - 10000;
      if (t[q] < 0) t[q] = 0;
      set_fields(q, o[q], d[q], c[q]); set_t4(q, t[q]);
    end
    wait_valid_a(12, ok);
    chk({tag, "_first_valid"}, 64'(ok), 1);
    for (int k = 0; k < AP; k++) begin
      p = (m_ptr + k) % AP;
      if (k > 0) begin nxt(); #1; chk({tag, "_valid"}, 64'(a_valid), 1); end
      exp_calc(o[p], d[p], c[p], t[p], AW, em, es, esat);
      chk({tag, "_port"}, 64'(a_port), 64'(p));
      chk({tag, "_mag"},  64'(a_off), em);
      chk({tag, "_sign"}, 64'(a_sign), 64'(es));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] em; logic es, esat; bit ok;
    int t0, nval;
    bit early;
    longint o, d, c, t;

    // Reset state
    repeat (3) nxt();
    #1;
    chk("rst_valid", 64'(a_valid), 0);
    chk("rst_mag",   64'(a_off), 0);
    chk("rst_sign",  64'(a_sign), 0);
    chk("rst_port",  64'(a_port), 0);
    chk("rst_sat",   64'(a_sat), 0);
    chk("rst_drop",  64'(a_drop), 0);
    nxt(); rst = 1'b0;

    // Port 0 fields, t4 three cycles later; exact latency from the t4 strobe
    nxt(); set_fields(0, 1000, 50, 20);
    nxt(); nxt(); nxt(); set_t4(0, 1060); t0 = cyc;
    wait_valid_a(12, ok);
    chk("t1_valid",   64'(ok), 1);
    chk("t1_latency", 64'(cyc - t0), 5);
    chk("t1_mag",     64'(a_off), 10);
    chk("t1_sign",    64'(a_sign), 0);
    chk("t1_port",    64'(a_port), 0);
    nxt(); #1;
    chk("t1_pulse",   64'(a_valid), 0);
    chk("t1_hold",    64'(a_off), 10);
    m_ptr = 1;

    // Port 2, t4 first, slave ahead of master
    pair(2, 1, 0, 1900, 40, 10, 2000);
    chk("t2_mag_const", 64'(a_off), 50);
    chk("t2_sign_const", 64'(a_sign), 1);

    // Zero difference
    pair(3, 2, 0, 100, 10, 5, 115);

    // Pointer is now 0: order 0,1,2,3; then serve port 1 so it sits at 2
    burst("rr0");
    pair(1, 0, 1, rnd40(), 7, 9, rnd40());
    burst("rr2");

    // Timeout on port 1: drop pulse exactly 16 cycles after the fields strobe
    nxt(); set_fields(1, 5, 5, 5); t0 = cyc; #1;
    chk("to_no_drop_at_strobe", 64'(a_drop[1]), 0);
    early = 1'b0;
    for (int i = 1; i < 16; i++) begin nxt(); #1; early |= a_drop[1]; end
    nxt(); #1;
    chk("to_no_early_drop", 64'(early), 0);
    chk("to_drop", 64'(a_drop[1]), 1);
    nxt(); #1;
    chk("to_drop_pulse", 64'(a_drop[1]), 0);
    nxt(); set_t4(1, 33); #1;
    chk("to_t4_accept_no_drop", 64'(a_drop[1]), 0);
    nval = 0;
    for (int i = 0; i < 10; i++) begin nxt(); #1; nval += int'(a_valid); end
    chk("to_t4_alone_no_output", 64'(nval), 0);
    repeat (12) nxt();

    // Overwrite in WAIT_T4: drop pulse, newer fields used
    nxt(); set_fields(3, 111, 1, 1); #1;
    chk("ow_first_no_drop", 64'(a_drop[3]), 0);
    nxt(); set_fields(3, 500, 7, 3); #1;
    chk("ow_drop", 64'(a_drop[3]), 1);
    nxt(); set_t4(3, 400);
    wait_valid_a(12, ok);
    chk("ow_valid", 64'(ok), 1);
    chk("ow_mag",   64'(a_off), 110);
    chk("ow_sign",  64'(a_sign), 0);
    m_ptr = 0;

    // Randomized single pairs, random arrival order and gap
    for (int n = 0; n < 16; n++) begin
      o = rnd40(); d = $urandom_range(5000, 0); c = $urandom_range(5000, 0);
      t = o + $urandom_range(20000, 0) - 10000;
      if (t < 0) t = 0;
      if (t >= (longint'(1) << AW)) t = (longint'(1) << AW) - 1;
      pair($urandom_range(AP - 1, 0), $urandom_range(2, 0), $urandom_range(3, 0), o, d, c, t);
    end

    // 8-bit instance: exact-max, just-over and far-over magnitudes
    for (int n = 0; n < 3; n++) begin
      longint so[3], sd[3], sc[3];
      so = '{255, 255, 255}; sd = '{0, 1, 255}; sc = '{0, 0, 255};
      exp_calc(so[n], sd[n], sc[n], 0, BW, em, es, esat);
      nxt();
      b_orig[0 +: BW] = so[n][BW-1:0]; b_pd[0 +: BW] = sd[n][BW-1:0];
      b_corr[0 +: BW] = sc[n][BW-1:0]; b_t4[0 +: BW] = '0;
      b_fv[0] = 1'b1; b_tv[0] = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 12 && !ok; i++) begin nxt(); #1; if (b_valid === 1'b1) ok = 1'b1; end
      chk("sat_valid", 64'(ok), 1);
      chk("sat_mag",   64'(b_off), em);
      chk("sat_flag",  64'(b_sat), 64'(esat));
      chk("sat_sign",  64'(b_sign), 0);
      chk("sat_port",  64'(b_port), 0);
      nxt(); #1;
      chk("sat_flag_pulse", 64'(b_sat), 0);
    end

    // Reset two cycles after a grant: in-flight result lost, outputs cleared
    nxt(); set_fields(0, 9000, 9, 9); set_t4(0, 7);
    nxt(); nxt(); nxt();
    rst = 1'b1; #1;
    chk("mrst_mag",   64'(a_off), 0);
    chk("mrst_sign",  64'(a_sign), 0);
    chk("mrst_port",  64'(a_port), 0);
    chk("mrst_b_mag", 64'(b_off), 0);
    nval = 0;
    nxt(); #1; nval += int'(a_valid);
    nxt(); rst = 1'b0; #1; nval += int'(a_valid);
    for (int i = 0; i < 8; i++) begin nxt(); #1; nval += int'(a_valid) + int'(a_sat); end
    chk("mrst_no_valid", 64'(nval), 0);
    m_ptr = 0;
    burst("post_rst");
    pair(2, 0, 2, 4242, 8, 8, 4000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ptp_sync_offset_calc
`default_nettype wire
